// File: rtl/s2f_pkg.sv
// Shared types and default constants for the slow-to-fast pulse pacer.
package s2f_pkg;
   typedef enum logic [1:0] {IDLE, HIGH, GAP} pacer_state_t;

   localparam int PULSE_W_DEF = 2;
   localparam int GAP_W_DEF   = 2;
   localparam int CNT_W_DEF   = 8;
   localparam int NUM_W_DEF   = 4;
   localparam int DROP_CNT_W  = 16;
endpackage

// File: rtl/s2f_sat_accum.sv
// Saturating accumulator: cur + add - dec, clamped to 2^W-1, reporting what the clamp removed.
module s2f_sat_accum
   import s2f_pkg::*;
#(
   parameter int W     = CNT_W_DEF,
   parameter int ADD_W = NUM_W_DEF
)(
   input  logic [W-1:0]     i_cur,
   input  logic [ADD_W-1:0] i_add,
   input  logic             i_dec,
   output logic [W-1:0]     o_next,
   output logic [ADD_W-1:0] o_drop
);
   // Wide enough that cur+add never wraps even when ADD_W exceeds W.
   localparam int SW = ((W > ADD_W) ? W : ADD_W) + 1;

   logic [SW-1:0] w_max, w_sum;
   logic          w_over;

   assign w_max  = {{(SW-W){1'b0}}, {W{1'b1}}};
   assign w_sum  = SW'(i_cur) + SW'(i_add) - SW'(i_dec);
   assign w_over = (w_sum > w_max);
   assign o_next = w_over ? {W{1'b1}} : W'(w_sum);
   assign o_drop = w_over ? ADD_W'(w_sum - w_max) : '0;
endmodule

// File: rtl/s2f_pulse_pacer.sv
// clk1-side pacer: accumulates bursty events and replays them as evenly spaced pulses.
// Define S2F_PACER_STATS_EN to build the saturating drop counter on o_drop_count.
module s2f_pulse_pacer
   import s2f_pkg::*;
#(
   parameter int PULSE_W = PULSE_W_DEF,
   parameter int GAP_W   = GAP_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int NUM_W   = NUM_W_DEF
)(
   input  logic                  clk1,
   input  logic                  reset,
   input  logic                  i_evt_valid,
   input  logic [NUM_W-1:0]      i_evt_num,
   input  logic                  i_enable,
   output logic                  o_pulse_out,
   output logic [CNT_W-1:0]      o_pending,
   output logic                  o_busy,
   output logic                  o_overflow,
   output logic [DROP_CNT_W-1:0] o_drop_count
);
   localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int TW   = $clog2(TMAX + 1);

   pacer_state_t     r_state, w_state_nxt;
   logic [TW-1:0]    r_timer, w_timer_nxt;
   logic             r_pulse, r_overflow, w_launch;
   logic [CNT_W-1:0] r_pending, w_pending_nxt;
   logic [NUM_W-1:0] w_add, w_drop;

   assign w_add = i_evt_valid ? i_evt_num : '0;

   // Launch decisions look only at the registered count; no same-cycle bypass.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_launch    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_enable && (r_pending != '0)) begin
               w_state_nxt = HIGH;
               w_timer_nxt = TW'(PULSE_W - 1);
               w_launch    = 1'b1;
            end
         end
         HIGH: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - TW'(1);
            end else begin
               w_state_nxt = GAP;
               w_timer_nxt = TW'(GAP_W - 1);
            end
         end
         GAP: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - TW'(1);
            end else if (i_enable && (r_pending != '0)) begin
               w_state_nxt = HIGH;
               w_timer_nxt = TW'(PULSE_W - 1);
               w_launch    = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   s2f_sat_accum #(.W(CNT_W), .ADD_W(NUM_W)) u_pend_accum (
      .i_cur  (r_pending),
      .i_add  (w_add),
      .i_dec  (w_launch),
      .o_next (w_pending_nxt),
      .o_drop (w_drop)
   );

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_pulse    <= 1'b0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_pulse    <= (w_state_nxt == HIGH);
         r_pending  <= w_pending_nxt;
         r_overflow <= r_overflow | (|w_drop);
      end
   end

`ifdef S2F_PACER_STATS_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt, w_drop_cnt_nxt;
   logic [NUM_W-1:0]      w_drop_cnt_unused;

   s2f_sat_accum #(.W(DROP_CNT_W), .ADD_W(NUM_W)) u_drop_accum (
      .i_cur  (r_drop_cnt),
      .i_add  (w_drop),
      .i_dec  (1'b0),
      .o_next (w_drop_cnt_nxt),
      .o_drop (w_drop_cnt_unused)
   );

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) r_drop_cnt <= '0;
      else       r_drop_cnt <= w_drop_cnt_nxt;
   end

   assign o_drop_count = r_drop_cnt;
`else
   assign o_drop_count = '0;
`endif

   assign o_pulse_out = r_pulse;
   assign o_pending   = r_pending;
   assign o_busy      = (r_state != IDLE);
   assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_s2f_pulse_pacer.sv
// Directed bench for s2f_pulse_pacer: default instance plus a CNT_W=3 instance for saturation.
module tb_s2f_pulse_pacer;
   logic        clk1 = 1'b0;
   logic        reset = 1'b1;
   logic        evt_valid = 1'b0, s_evt_valid = 1'b0;
   logic [3:0]  evt_num = '0, s_evt_num = '0;
   logic        enable = 1'b0, s_enable = 1'b0;
   logic        pulse_out, s_pulse_out;
   logic [7:0]  pending;
   logic [2:0]  s_pending;
   logic        busy, s_busy, overflow, s_overflow;
   logic [15:0] drop_count, s_drop_count;

   int n_assert = 0;
   int n_fail   = 0;
   logic [15:0] exp_drop;

   always #5 clk1 = ~clk1;

   s2f_pulse_pacer u_dut (
      .clk1(clk1), .reset(reset), .i_evt_valid(evt_valid), .i_evt_num(evt_num),
      .i_enable(enable), .o_pulse_out(pulse_out), .o_pending(pending), .o_busy(busy),
      .o_overflow(overflow), .o_drop_count(drop_count)
   );

   s2f_pulse_pacer #(.CNT_W(3)) u_sat (
      .clk1(clk1), .reset(reset), .i_evt_valid(s_evt_valid), .i_evt_num(s_evt_num),
      .i_enable(s_enable), .o_pulse_out(s_pulse_out), .o_pending(s_pending), .o_busy(s_busy),
      .o_overflow(s_overflow), .o_drop_count(s_drop_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   initial begin
`ifdef S2F_PACER_STATS_EN
      exp_drop = 16'd3;
`else
      exp_drop = 16'd0;
`endif
      // reset state
      #2;
      check("rst_pulse", 32'(pulse_out), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_drop", 32'(drop_count), 0);
      tick();
      reset = 1'b0;
      tick();

      // saturation on the CNT_W=3 instance, enable held low
      s_evt_valid = 1'b1; s_evt_num = 4'd6;
      tick();
      check("sat_pend6", 32'(s_pending), 6);
      check("sat_ovf0", 32'(s_overflow), 0);
      s_evt_num = 4'd4;
      tick();
      check("sat_pend7", 32'(s_pending), 7);
      check("sat_ovf1", 32'(s_overflow), 1);
      check("sat_drop", 32'(s_drop_count), 32'(exp_drop));
      // launch at saturation frees one slot before the clamp
      s_enable = 1'b1; s_evt_num = 4'd1;
      tick();
      check("sat_launch_pend", 32'(s_pending), 7);
      check("sat_launch_pulse", 32'(s_pulse_out), 1);
      check("sat_launch_drop", 32'(s_drop_count), 32'(exp_drop));
      s_evt_valid = 1'b0; s_enable = 1'b0;

      // single event
      enable = 1'b1; evt_valid = 1'b1; evt_num = 4'd1;
      tick();
      check("one_e0_pend", 32'(pending), 1);
      check("one_e0_pulse", 32'(pulse_out), 0);
      evt_valid = 1'b0;
      tick();
      check("one_e1_pulse", 32'(pulse_out), 1);
      check("one_e1_pend", 32'(pending), 0);
      check("one_e1_busy", 32'(busy), 1);
      tick();
      check("one_e2_pulse", 32'(pulse_out), 1);
      tick();
      check("one_e3_pulse", 32'(pulse_out), 0);
      tick();
      check("one_e4_busy", 32'(busy), 1);
      tick();
      check("one_e5_busy", 32'(busy), 0);

      // evt_num=0 is a no-op
      evt_valid = 1'b1; evt_num = 4'd0;
      tick();
      evt_valid = 1'b0;
      tick();
      check("zero_pend", 32'(pending), 0);
      check("zero_busy", 32'(busy), 0);

      // burst of 5: period 4, pending 5..0
      evt_valid = 1'b1; evt_num = 4'd5;
      tick();
      evt_valid = 1'b0;
      check("burst_e0_pend", 32'(pending), 5);
      for (int p = 0; p < 5; p++) begin
         tick();
         check("burst_hi1", 32'(pulse_out), 1);
         check("burst_pend", 32'(pending), 32'(4 - p));
         tick();
         check("burst_hi2", 32'(pulse_out), 1);
         tick();
         check("burst_lo1", 32'(pulse_out), 0);
         tick();
         check("burst_lo2", 32'(pulse_out), 0);
      end
      tick();
      check("burst_idle", 32'(busy), 0);
      check("burst_ovf", 32'(overflow), 0);

      // enable dropped mid-HIGH: finish pulse and gap, then idle
      evt_valid = 1'b1; evt_num = 4'd3;
      tick();
      evt_valid = 1'b0;
      tick();
      check("en_e1_pulse", 32'(pulse_out), 1);
      check("en_e1_pend", 32'(pending), 2);
      enable = 1'b0;
      tick();
      check("en_e2_pulse", 32'(pulse_out), 1);
      tick();
      check("en_e3_pulse", 32'(pulse_out), 0);
      tick();
      check("en_e4_busy", 32'(busy), 1);
      tick();
      check("en_e5_busy", 32'(busy), 0);
      check("en_e5_pend", 32'(pending), 2);
      tick();
      check("en_e6_pulse", 32'(pulse_out), 0);
      enable = 1'b1;
      tick();
      check("en_e7_pulse", 32'(pulse_out), 1);
      check("en_e7_pend", 32'(pending), 1);
      repeat (4) tick();
      check("en_e11_pulse", 32'(pulse_out), 1);
      check("en_e11_pend", 32'(pending), 0);
      repeat (4) tick();
      check("en_e15_busy", 32'(busy), 0);

      // simultaneous add and launch at end of GAP
      evt_valid = 1'b1; evt_num = 4'd2;
      tick();
      evt_valid = 1'b0;
      tick();
      check("sim_e1_pend", 32'(pending), 1);
      repeat (3) tick();
      check("sim_e4_pulse", 32'(pulse_out), 0);
      evt_valid = 1'b1; evt_num = 4'd2;
      tick();
      evt_valid = 1'b0;
      check("sim_e5_pulse", 32'(pulse_out), 1);
      check("sim_e5_pend", 32'(pending), 2);

      // reset mid-HIGH with pending=4
      evt_valid = 1'b1; evt_num = 4'd2;
      tick();
      evt_valid = 1'b0;
      check("rmid_pulse", 32'(pulse_out), 1);
      check("rmid_pend", 32'(pending), 4);
      #1 reset = 1'b1;
      #1;
      check("rmid_async_pulse", 32'(pulse_out), 0);
      check("rmid_async_pend", 32'(pending), 0);
      check("rmid_async_busy", 32'(busy), 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_rst_pulse", 32'(pulse_out), 0);
         check("post_rst_busy", 32'(busy), 0);
      end
      check("post_rst_pend", 32'(pending), 0);
      check("post_rst_ovf", 32'(overflow), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
